// File: rtl/iir_coeff_bank.sv
// Double-buffered coefficient bank for the 2nd-order IIR filter. GPIO writes go to
// a shadow bank, and a commit edge copies the whole bank into the active registers.
module iir_coeff_bank #(
  parameter int COEFF_WIDTH  = 32,
  parameter int LOG_A0       = 30,
  parameter int RESET_GAIN   = 65536,
  parameter int FLUSH_CYCLES = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [2:0]             wr_addr,
  input  logic [COEFF_WIDTH-1:0] wr_data,
  input  logic                   commit,
  input  logic                   sample_tick,
  input  logic                   err_clr,
  output logic [COEFF_WIDTH-1:0] b0,
  output logic [COEFF_WIDTH-1:0] b1,
  output logic [COEFF_WIDTH-1:0] b2,
  output logic [COEFF_WIDTH-1:0] a1,
  output logic [COEFF_WIDTH-1:0] a2,
  output logic [COEFF_WIDTH-1:0] gain,
  output logic                   filter_clr,
  output logic                   busy,
  output logic                   pending,
  output logic [15:0]            load_count,
  output logic [1:0]             err
);

  localparam int CNT_W = (FLUSH_CYCLES < 2) ? 1 : $clog2(FLUSH_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    FLUSH = 2'd2
  } state_t;

  state_t                        state;
  state_t                        next_state;
  logic                          commit_d;
  logic                          req;
  logic                          req_bad;
  logic                          addr_ok;
  logic                          wr_ok;
  logic                          wr_bad;
  logic                          load;
  logic [CNT_W-1:0]              flush_cnt;
  logic signed [COEFF_WIDTH-1:0] shadow [6];

  // Reset image of the bank: b0 carries the normalisation 2^LOG_A0, gain is unity.
  function automatic logic signed [COEFF_WIDTH-1:0] reset_word(input int idx);
    case (idx)
      0:       reset_word = COEFF_WIDTH'(1) << LOG_A0;
      5:       reset_word = COEFF_WIDTH'(RESET_GAIN);
      default: reset_word = '0;
    endcase
  endfunction

  assign req     = commit & ~commit_d;
  assign req_bad = req & (state != IDLE);
  assign addr_ok = (wr_addr <= 3'd5);
  assign wr_ok   = wr_en & addr_ok & (state != ARMED);
  assign wr_bad  = wr_en & ~wr_ok;
  assign load    = (state == ARMED) & sample_tick;

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (req) next_state = ARMED;
      ARMED:   if (sample_tick) next_state = (FLUSH_CYCLES > 0) ? FLUSH : IDLE;
      FLUSH:   if (flush_cnt == CNT_W'(1)) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      commit_d   <= 1'b0;
      flush_cnt  <= '0;
      busy       <= 1'b0;
      filter_clr <= 1'b0;
    end else begin
      state      <= next_state;
      commit_d   <= commit;
      busy       <= (next_state != IDLE);
      filter_clr <= (next_state == FLUSH);
      if (load)
        flush_cnt <= CNT_W'(FLUSH_CYCLES);
      else if (state == FLUSH)
        flush_cnt <= flush_cnt - CNT_W'(1);
    end
  end

  // Loads only happen in ARMED, where writes are refused, so a load never races a write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 6; i++) shadow[i] <= reset_word(i);
      b0         <= reset_word(0);
      b1         <= reset_word(1);
      b2         <= reset_word(2);
      a1         <= reset_word(3);
      a2         <= reset_word(4);
      gain       <= reset_word(5);
      pending    <= 1'b0;
      load_count <= '0;
      err        <= '0;
    end else begin
      if (wr_ok) begin
        shadow[wr_addr] <= wr_data;
        pending         <= 1'b1;
      end
      if (load) begin
        b0         <= shadow[0];
        b1         <= shadow[1];
        b2         <= shadow[2];
        a1         <= shadow[3];
        a2         <= shadow[4];
        gain       <= shadow[5];
        pending    <= 1'b0;
        load_count <= load_count + 16'd1;
      end
      err <= (err_clr ? 2'b00 : err) | {req_bad, wr_bad};
    end
  end

endmodule

// File: tb/tb_iir_coeff_bank.sv
// Bench for iir_coeff_bank: reference model plus a load scoreboard drained by a monitor.
module tb_iir_coeff_bank;
  localparam int W = 32;
  localparam int F = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          wr_en;
  logic [2:0]    wr_addr;
  logic [W-1:0]  wr_data;
  logic          commit;
  logic          sample_tick;
  logic          err_clr;
  logic [W-1:0]  b0, b1, b2, a1, a2, gain;
  logic          filter_clr, busy, pending;
  logic [15:0]   load_count;
  logic [1:0]    err;

  always #5 clk = ~clk;

  iir_coeff_bank #(
    .COEFF_WIDTH(W), .LOG_A0(30), .RESET_GAIN(65536), .FLUSH_CYCLES(F)
  ) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .commit(commit), .sample_tick(sample_tick), .err_clr(err_clr),
    .b0(b0), .b1(b1), .b2(b2), .a1(a1), .a2(a2), .gain(gain),
    .filter_clr(filter_clr), .busy(busy), .pending(pending),
    .load_count(load_count), .err(err)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a bank image, a pending flag, a "waiting for tick" flag and the
  // number of flush cycles still owed to the filter.
  typedef struct packed {
    logic [5:0][W-1:0] c;
    logic [15:0]       n;
  } load_t;

  load_t             exp_q[$];
  logic [5:0][W-1:0] m_shadow, m_active;
  bit                m_pending, m_waiting, m_prev_commit;
  int                m_flush_left;
  logic [15:0]       m_count;
  logic [1:0]        m_err;

  function automatic logic [5:0][W-1:0] reset_bank();
    logic [5:0][W-1:0] bank;
    bank    = '0;
    bank[0] = 32'h4000_0000;
    bank[5] = 32'h0001_0000;
    return bank;
  endfunction

  task automatic model_reset();
    m_shadow      = reset_bank();
    m_active      = reset_bank();
    m_pending     = 0;
    m_waiting     = 0;
    m_prev_commit = 0;
    m_flush_left  = 0;
    m_count       = '0;
    m_err         = '0;
  endtask

  task automatic model_step();
    bit       req;
    bit       do_load;
    logic [1:0] new_err;
    if (rst) begin
      model_reset();
      return;
    end
    req           = commit && !m_prev_commit;
    m_prev_commit = commit;
    new_err       = '0;
    do_load       = 0;
    if (wr_en) begin
      if (m_waiting || wr_addr > 3'd5) new_err[0] = 1'b1;
      else begin
        m_shadow[wr_addr] = wr_data;
        m_pending         = 1;
      end
    end
    if (m_waiting) begin
      if (req) new_err[1] = 1'b1;
      if (sample_tick) do_load = 1;
    end else if (m_flush_left > 0) begin
      if (req) new_err[1] = 1'b1;
      m_flush_left--;
    end else if (req) begin
      m_waiting = 1;
    end
    if (do_load) begin
      m_active     = m_shadow;
      m_pending    = 0;
      m_count      = m_count + 16'd1;
      m_waiting    = 0;
      m_flush_left = F;
      exp_q.push_back({m_active, m_count});
    end
    m_err = (err_clr ? 2'b00 : m_err) | new_err;
  endtask

  task automatic compare_all();
    check("b0", b0, m_active[0]);
    check("b1", b1, m_active[1]);
    check("b2", b2, m_active[2]);
    check("a1", a1, m_active[3]);
    check("a2", a2, m_active[4]);
    check("gain", gain, m_active[5]);
    check("busy", busy, (m_waiting || m_flush_left > 0));
    check("filter_clr", filter_clr, (m_flush_left > 0));
    check("pending", pending, m_pending);
    check("load_count", load_count, m_count);
    check("err", err, m_err);
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic write(input logic [2:0] addr, input logic [W-1:0] data);
    wr_en   = 1'b1;
    wr_addr = addr;
    wr_data = data;
    tick();
    wr_en   = 1'b0;
  endtask

  // Monitor: any change of the active bank or load counter outside reset is a load
  // and must match the next scoreboard entry.
  initial begin : monitor
    logic [5:0][W-1:0] last, cur;
    logic [15:0]       last_n;
    load_t             e;
    last   = reset_bank();
    last_n = '0;
    forever begin
      @(negedge clk);
      cur[0] = b0; cur[1] = b1; cur[2] = b2;
      cur[3] = a1; cur[4] = a2; cur[5] = gain;
      if (rst) begin
        last   = cur;
        last_n = load_count;
      end else if (cur !== last || load_count !== last_n) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_load: load_count 0x%0h, no load expected", load_count);
        end else begin
          e = exp_q.pop_front();
          for (int i = 0; i < 6; i++) check("load_coef", cur[i], e.c[i]);
          check("load_num", load_count, e.n);
        end
        last   = cur;
        last_n = load_count;
      end
    end
  end

  int          clr_cycles;
  int          r, t, load_i;
  logic [15:0] cnt0;

  initial begin : stimulus
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    commit = 1'b0; sample_tick = 1'b1; err_clr = 1'b0;
    model_reset();

    // Reset defaults
    repeat (3) tick();
    rst = 1'b0;
    check("rst_b0", b0, 32'h4000_0000);
    check("rst_gain", gain, 32'h0001_0000);
    check("rst_b1", b1, 0);
    check("rst_a1", a1, 0);
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
    check("rst_count", load_count, 0);
    tick();

    // Atomic load with tick tied high
    write(3'd0, 32'h1000_0000);
    write(3'd3, 32'hC000_0000);
    write(3'd5, 32'h0002_0000);
    check("pre_b0", b0, 32'h4000_0000);
    check("pre_a1", a1, 0);
    check("pre_pending", pending, 1);
    commit = 1'b1;
    tick();
    commit = 1'b0;
    check("req_busy", busy, 1);
    check("req_b0_old", b0, 32'h4000_0000);
    tick();
    check("atomic_b0", b0, 32'h1000_0000);
    check("atomic_a1", a1, 32'hC000_0000);
    check("atomic_gain", gain, 32'h0002_0000);
    check("atomic_pending", pending, 0);
    check("atomic_count", load_count, 1);
    clr_cycles = 0;
    repeat (12) begin
      if (filter_clr) clr_cycles++;
      tick();
    end
    check("flush_len", clr_cycles, F);
    check("flush_busy_end", busy, 0);

    // Tick alignment: tick every 10 cycles, commit at a random cycle
    r      = $urandom_range(3, 25);
    t      = (r / 10 + 1) * 10;
    load_i = -1;
    cnt0   = load_count;
    for (int i = 0; i < 60; i++) begin
      sample_tick = (i % 10 == 0);
      commit      = (i == r);
      wr_en       = (i == 1);
      wr_addr     = 3'($urandom_range(0, 5));
      wr_data     = $urandom;
      tick();
      if (load_i < 0 && load_count != cnt0) load_i = i;
    end
    wr_en  = 1'b0;
    commit = 1'b0;
    check("tick_align", load_i, t);

    // Rejections
    sample_tick = 1'b0;
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    commit = 1'b1;
    tick();
    commit = 1'b0;
    write(3'd2, 32'hDEAD_BEEF);
    check("err_armed_write", err, 2'b01);
    sample_tick = 1'b1;
    tick();
    write(3'd7, 32'h1234_5678);
    commit = 1'b1;
    tick();
    commit = 1'b0;
    check("err_both", err, 2'b11);
    repeat (10) tick();
    check("b2_not_written", (b2 == 32'hDEAD_BEEF), 0);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("err_cleared", err, 0);

    // Commit held high for 50 cycles
    cnt0   = load_count;
    commit = 1'b1;
    repeat (50) tick();
    commit = 1'b0;
    repeat (12) tick();
    check("held_one_load", load_count - cnt0, 1);
    check("held_no_err1", err[1], 0);
    check("held_b2_kept", (b2 == 32'hDEAD_BEEF), 0);

    // Reset at cycle 3 of FLUSH
    write(3'd1, $urandom);
    commit = 1'b1;
    tick();
    commit = 1'b0;
    tick();
    tick();
    tick();
    check("clr_before_rst", filter_clr, 1);
    #2;
    rst = 1'b1;
    #1;
    check("rst_async_clr", filter_clr, 0);
    check("rst_async_busy", busy, 0);
    check("rst_async_b0", b0, 32'h4000_0000);
    check("rst_async_b1", b1, 0);
    check("rst_async_gain", gain, 32'h0001_0000);
    check("rst_async_count", load_count, 0);
    check("rst_async_pending", pending, 0);
    model_reset();
    tick();
    rst = 1'b0;
    tick();

    // Randomised traffic
    repeat (800) begin
      wr_en       = ($urandom_range(0, 2) == 0);
      wr_addr     = 3'($urandom_range(0, 7));
      wr_data     = $urandom;
      if ($urandom_range(0, 7) == 0) commit = ~commit;
      sample_tick = ($urandom_range(0, 3) == 0);
      err_clr     = ($urandom_range(0, 15) == 0);
      tick();
    end
    wr_en = 1'b0; commit = 1'b0; err_clr = 1'b0; sample_tick = 1'b1;
    repeat (20) tick();
    @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
